// File: rtl/cross_bar_mem_slave.sv
// ============================================================================
// Module   : cross_bar_mem_slave
// Purpose  : Responder endpoint for the cross-bar req/ack protocol, serving
//            reads/writes from a word-addressed memory after programmable waits.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cross_bar_mem_slave #(
    parameter int unsigned          DWIDTH      = 32,
    parameter int unsigned          AWIDTH      = 32,
    parameter int unsigned          DEPTH       = 256,
    parameter logic [AWIDTH-1:0]    BASE_ADDR   = '0,
    parameter int unsigned          WAIT_STATES = 2
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              req,
    input  logic [AWIDTH-1:0] addr,
    input  logic              cmd,
    input  logic [DWIDTH-1:0] wdata,
    output logic              ack,
    output logic [DWIDTH-1:0] rdata,
    output logic              resp,
    output logic              addr_err
);

    localparam int unsigned       IW       = $clog2(DEPTH);
    localparam logic [AWIDTH:0]   ADDR_LO  = {1'b0, BASE_ADDR};
    localparam logic [AWIDTH:0]   SPAN     = (AWIDTH+1)'(DEPTH);
    localparam logic [3:0]        CNT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic [AWIDTH-1:0]   addr_q;
    logic                cmd_q;
    logic [DWIDTH-1:0]   wdata_q;
    logic [DWIDTH-1:0]   mem [DEPTH];

    logic [AWIDTH:0]     offset;
    logic                in_range;
    logic [IW-1:0]       index;
    logic                mem_we;

    // An address below the base wraps to >= 2^AWIDTH, so one compare covers both bounds.
    assign offset   = {1'b0, addr_q} - ADDR_LO;
    assign in_range = (offset < SPAN);
    assign index    = offset[IW-1:0];
    assign mem_we   = (state == S_ACK) && cmd_q && in_range;

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            mem[index] <= wdata_q;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            cmd_q    <= 1'b0;
            wdata_q  <= '0;
            ack      <= 1'b0;
            resp     <= 1'b0;
            addr_err <= 1'b0;
            rdata    <= '0;
        end else begin
            ack      <= 1'b0;
            resp     <= 1'b0;
            addr_err <= 1'b0;
            rdata    <= '0;
            case (state)
                // RESP accepts a new request exactly like IDLE, giving WAIT_STATES+2 throughput.
                S_IDLE, S_RESP: begin
                    if (req) begin
                        addr_q  <= addr;
                        cmd_q   <= cmd;
                        wdata_q <= wdata;
                        cnt     <= CNT_INIT;
                        if (CNT_INIT == 4'd0) begin
                            state <= S_ACK;
                            ack   <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt <= 4'd1) begin
                        state <= S_ACK;
                        ack   <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    state    <= S_RESP;
                    resp     <= 1'b1;
                    addr_err <= !in_range;
                    if (!cmd_q && in_range) begin
                        rdata <= mem[index];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cross_bar_mem_slave.sv
// ============================================================================
// Module   : tb_cross_bar_mem_slave
// Purpose  : Directed self-checking bench for cross_bar_mem_slave.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cross_bar_mem_slave;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        req;
    logic [31:0] addr;
    logic        cmd;
    logic [31:0] wdata;

    logic        ack_a, resp_a, err_a;
    logic [31:0] rdata_a;
    logic        ack_b, resp_b, err_b;
    logic [31:0] rdata_b;
    logic        ack_c, resp_c, err_c;
    logic [31:0] rdata_c;

    int          sel;
    logic        ack_s, resp_s, err_s;
    logic [31:0] rdata_s;

    int          cyc = 0;
    int          n_err = 0;
    int          n_checks = 0;

    logic        s_cmd   [8];
    logic [31:0] s_addr  [8];
    logic [31:0] s_wdata [8];
    int          a_cyc   [8];
    int          r_cyc   [8];
    logic [31:0] r_data  [8];
    logic        r_err   [8];

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    cross_bar_mem_slave #(.DWIDTH(32), .AWIDTH(32), .DEPTH(256),
                          .BASE_ADDR(32'h0), .WAIT_STATES(2)) u_dut_a (
        .aclk(aclk), .aresetn(aresetn), .req(req), .addr(addr), .cmd(cmd),
        .wdata(wdata), .ack(ack_a), .rdata(rdata_a), .resp(resp_a), .addr_err(err_a));

    cross_bar_mem_slave #(.DWIDTH(32), .AWIDTH(32), .DEPTH(256),
                          .BASE_ADDR(32'h100), .WAIT_STATES(2)) u_dut_b (
        .aclk(aclk), .aresetn(aresetn), .req(req), .addr(addr), .cmd(cmd),
        .wdata(wdata), .ack(ack_b), .rdata(rdata_b), .resp(resp_b), .addr_err(err_b));

    cross_bar_mem_slave #(.DWIDTH(32), .AWIDTH(32), .DEPTH(256),
                          .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut_c (
        .aclk(aclk), .aresetn(aresetn), .req(req), .addr(addr), .cmd(cmd),
        .wdata(wdata), .ack(ack_c), .rdata(rdata_c), .resp(resp_c), .addr_err(err_c));

    always_comb begin
        ack_s   = ack_a;
        resp_s  = resp_a;
        err_s   = err_a;
        rdata_s = rdata_a;
        if (sel == 1) begin
            ack_s = ack_b; resp_s = resp_b; err_s = err_b; rdata_s = rdata_b;
        end else if (sel == 2) begin
            ack_s = ack_c; resp_s = resp_c; err_s = err_c; rdata_s = rdata_c;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic c, input logic [31:0] a, input logic [31:0] d);
        s_cmd[i]   = c;
        s_addr[i]  = a;
        s_wdata[i] = d;
    endtask

    task automatic load_req(input int i);
        req   = 1'b1;
        cmd   = s_cmd[i];
        addr  = s_addr[i];
        wdata = s_wdata[i];
    endtask

    // Issues n queued requests, presenting the next one as soon as ack is seen.
    task automatic run_seq(input int n);
        int ap = 0;
        int rp = 0;
        int c0;
        int budget = 0;
        for (int i = 0; i < 8; i++) begin
            a_cyc[i] = -1; r_cyc[i] = -1; r_data[i] = 'x; r_err[i] = 1'bx;
        end
        @(posedge aclk); #1;
        load_req(0);
        c0 = cyc;
        while (rp < n && budget < 30 * n + 20) begin
            @(negedge aclk);
            budget++;
            if (resp_s) begin
                if (rp < n) begin
                    r_cyc[rp]  = cyc - c0;
                    r_data[rp] = rdata_s;
                    r_err[rp]  = err_s;
                end
                rp++;
            end
            if (ack_s) begin
                if (ap < 8) a_cyc[ap] = cyc - c0;
                ap++;
                if (ap < n) load_req(ap);
                else        req = 1'b0;
            end
        end
        req = 1'b0;
        check("seq_resp_count", rp, n);
    endtask

    task automatic do_reset();
        req = 1'b0;
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        sel = 0; req = 0; cmd = 0; addr = 0; wdata = 0; aresetn = 0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1;

        // Reset during random traffic
        repeat (23) begin
            @(negedge aclk);
            req   = 1'($urandom_range(0, 1));
            cmd   = 1'($urandom_range(0, 1));
            addr  = 32'($urandom_range(0, 511));
            wdata = $urandom;
        end
        aresetn = 0; req = 0;
        #1;
        check("rst_ack", {31'd0, ack_a}, 32'd0);
        check("rst_resp", {31'd0, resp_a}, 32'd0);
        check("rst_rdata", rdata_a, 32'd0);
        check("rst_err", {31'd0, err_a}, 32'd0);
        check("rst_ack_c", {31'd0, ack_c}, 32'd0);
        @(negedge aclk);
        aresetn = 1;
        acks = 0;
        repeat (6) begin
            @(negedge aclk);
            if (ack_a || resp_a) acks++;
        end
        check("rst_idle_no_ack", acks, 0);

        // Single write then read, WAIT_STATES=2
        sel = 0;
        set_req(0, 1'b1, 32'h10, 32'hA5A5_0001);
        run_seq(1);
        check("wr_ack_cyc", a_cyc[0], 3);
        check("wr_resp_cyc", r_cyc[0], 4);
        check("wr_err", {31'd0, r_err[0]}, 32'd0);
        check("wr_rdata_zero", r_data[0], 32'd0);
        set_req(0, 1'b0, 32'h10, 32'h0);
        run_seq(1);
        check("rd_data", r_data[0], 32'hA5A5_0001);
        check("rd_err", {31'd0, r_err[0]}, 32'd0);

        // Back-to-back writes with req held
        set_req(0, 1'b1, 32'h0, 32'h1);
        set_req(1, 1'b1, 32'h1, 32'h2);
        set_req(2, 1'b1, 32'h2, 32'h3);
        run_seq(3);
        check("b2b_ack0", a_cyc[0], 3);
        check("b2b_ack1", a_cyc[1], 7);
        check("b2b_ack2", a_cyc[2], 11);
        set_req(0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 32'h1, 32'h0);
        set_req(2, 1'b0, 32'h2, 32'h0);
        run_seq(3);
        check("b2b_rd0", r_data[0], 32'h1);
        check("b2b_rd1", r_data[1], 32'h2);
        check("b2b_rd2", r_data[2], 32'h3);

        // Address decode, BASE_ADDR=0x100
        sel = 1;
        set_req(0, 1'b1, 32'h200, 32'hFFFF_FFFF);
        set_req(1, 1'b1, 32'h1FF, 32'h0000_1234);
        set_req(2, 1'b0, 32'h200, 32'h0);
        set_req(3, 1'b0, 32'h1FF, 32'h0);
        set_req(4, 1'b0, 32'h0FF, 32'h0);
        run_seq(5);
        check("oor_wr_err", {31'd0, r_err[0]}, 32'd1);
        check("top_wr_err", {31'd0, r_err[1]}, 32'd0);
        check("oor_rd_data", r_data[2], 32'd0);
        check("oor_rd_err", {31'd0, r_err[2]}, 32'd1);
        check("top_rd_data", r_data[3], 32'h0000_1234);
        check("top_rd_err", {31'd0, r_err[3]}, 32'd0);
        check("below_rd_err", {31'd0, r_err[4]}, 32'd1);

        // Reset while a write sits in WAIT
        sel = 0;
        set_req(0, 1'b1, 32'h20, 32'h55);
        run_seq(1);
        @(posedge aclk); #1;
        req = 1; cmd = 1; addr = 32'h20; wdata = 32'hAA;
        repeat (2) @(negedge aclk);
        aresetn = 0; req = 0;
        #1;
        check("midrst_ack", {31'd0, ack_a}, 32'd0);
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1;
        acks = 0;
        repeat (8) begin
            @(negedge aclk);
            if (ack_a) acks++;
        end
        check("midrst_no_ack", acks, 0);
        set_req(0, 1'b0, 32'h20, 32'h0);
        run_seq(1);
        check("midrst_rd", r_data[0], 32'h55);

        // WAIT_STATES=0 instance
        sel = 2;
        do_reset();
        set_req(0, 1'b1, 32'h5, 32'h77);
        set_req(1, 1'b1, 32'h6, 32'h88);
        run_seq(2);
        check("w0_wr_ack0", a_cyc[0], 1);
        check("w0_wr_ack1", a_cyc[1], 3);
        set_req(0, 1'b0, 32'h5, 32'h0);
        set_req(1, 1'b0, 32'h6, 32'h0);
        set_req(2, 1'b0, 32'h5, 32'h0);
        run_seq(3);
        check("w0_rd_ack0", a_cyc[0], 1);
        check("w0_rd_resp0", r_cyc[0], 2);
        check("w0_rd_ack1", a_cyc[1], 3);
        check("w0_rd_ack2", a_cyc[2], 5);
        check("w0_rd0", r_data[0], 32'h77);
        check("w0_rd1", r_data[1], 32'h88);
        check("w0_rd2", r_data[2], 32'h77);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
